// File: rtl/fifo_rd_stream.sv
// Read-side drain engine: pulls words from the dual-clock FIFO and re-presents
// them as a valid/ready stream through a small credit-controlled elastic buffer.
module fifo_rd_stream #(
  parameter int DWIDTH = 8,
  parameter int RD_LAT = 1,
  parameter int CWIDTH = 16
) (
  input  logic              rd_clk,
  input  logic              areset,
  input  logic              fifo_empty,
  input  logic [DWIDTH-1:0] fifo_q,
  output logic              fifo_read,
  output logic [DWIDTH-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CWIDTH-1:0] words_out,
  output logic              underrun,
  output logic              busy
);
  localparam int BDEPTH = RD_LAT + 1;
  localparam logic [1:0] LAST_IDX = 2'(BDEPTH - 1);
  localparam logic [2:0] BDEPTH_W = 3'(BDEPTH);

  logic              run;
  logic [RD_LAT-1:0] pending;
  logic [RD_LAT-1:0] pending_next;
  logic [DWIDTH-1:0] buf_mem [0:3];
  logic [1:0]        head;
  logic [1:0]        tail;
  logic [1:0]        occ;
  logic [1:0]        inflight;
  logic              push;
  logic              pop;
  logic [2:0]        credit_used;

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + 2'(pending[i]);
  end

  // A read only issues when the buffer slot it will land in is already guaranteed.
  assign m_valid     = (occ != 2'd0);
  assign m_data      = buf_mem[head];
  assign pop         = m_valid & m_ready;
  assign push        = pending[RD_LAT-1];
  assign busy        = (occ != 2'd0) | (inflight != 2'd0);
  assign credit_used = 3'(occ) + 3'(inflight) - 3'(pop);
  assign fifo_read   = run & ~fifo_empty & (credit_used < BDEPTH_W);

  always_comb begin
    pending_next    = pending << 1;
    pending_next[0] = fifo_read;
  end

  // run holds off the first strobe until a clock edge has passed with reset low.
  always_ff @(posedge rd_clk or posedge areset) begin
    if (areset) begin
      run       <= 1'b0;
      pending   <= '0;
      head      <= 2'd0;
      tail      <= 2'd0;
      occ       <= 2'd0;
      words_out <= '0;
      underrun  <= 1'b0;
      for (int i = 0; i < 4; i++) buf_mem[i] <= '0;
    end else begin
      run     <= 1'b1;
      pending <= pending_next;
      if (push) begin
        buf_mem[tail] <= fifo_q;
        tail          <= (tail == LAST_IDX) ? 2'd0 : tail + 2'd1;
      end
      if (pop) begin
        head      <= (head == LAST_IDX) ? 2'd0 : head + 2'd1;
        words_out <= words_out + CWIDTH'(1);
      end
      occ      <= occ + 2'(push) - 2'(pop);
      underrun <= underrun | (fifo_read & fifo_empty);
    end
  end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// Bench for fifo_rd_stream: instance a (RD_LAT=1, CWIDTH=4) and instance b (RD_LAT=2),
// each fed by a behavioural FIFO with read latency and watched by a stream monitor.
module tb_fifo_rd_stream;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic areset = 1'b1;
  logic a_fifo_empty, a_fifo_read, a_m_valid, a_underrun, a_busy;
  logic b_fifo_empty, b_fifo_read, b_m_valid, b_underrun, b_busy;
  logic a_m_ready = 1'b0;
  logic b_m_ready = 1'b0;
  logic [7:0] a_fifo_q, a_m_data, b_fifo_q, b_m_data;
  logic [3:0] words_a;
  logic [15:0] words_b;

  fifo_rd_stream #(.DWIDTH(8), .RD_LAT(1), .CWIDTH(4)) dut_a (
    .rd_clk(clk), .areset(areset), .fifo_empty(a_fifo_empty), .fifo_q(a_fifo_q),
    .fifo_read(a_fifo_read), .m_data(a_m_data), .m_valid(a_m_valid), .m_ready(a_m_ready),
    .words_out(words_a), .underrun(a_underrun), .busy(a_busy));

  fifo_rd_stream #(.DWIDTH(8), .RD_LAT(2), .CWIDTH(16)) dut_b (
    .rd_clk(clk), .areset(areset), .fifo_empty(b_fifo_empty), .fifo_q(b_fifo_q),
    .fifo_read(b_fifo_read), .m_data(b_m_data), .m_valid(b_m_valid), .m_ready(b_m_ready),
    .words_out(words_b), .underrun(b_underrun), .busy(b_busy));

  // Behavioural FIFOs: write side driven by the tests, read pointer shares the reset.
  logic [7:0] a_mem [0:4095];
  logic [7:0] b_mem [0:4095];
  int a_wr = 0, b_wr = 0, a_rd, b_rd;
  logic [7:0] a_q1, b_q1, b_q2;

  assign a_fifo_empty = (a_rd == a_wr);
  assign b_fifo_empty = (b_rd == b_wr);
  assign a_fifo_q = a_q1;
  assign b_fifo_q = b_q2;

  always @(posedge clk or posedge areset) begin
    if (areset) begin
      a_rd <= 0; b_rd <= 0; a_q1 <= '0; b_q1 <= '0; b_q2 <= '0;
    end else begin
      if (a_fifo_read) a_rd <= a_rd + 1;
      if (b_fifo_read) b_rd <= b_rd + 1;
      a_q1 <= a_mem[a_rd[11:0]];
      b_q1 <= b_mem[b_rd[11:0]];
      b_q2 <= b_q1;
    end
  end

  // Stream monitor: collects delivered words and counts protocol violations.
  logic [7:0] got_a[$];
  logic [7:0] got_b[$];
  int empty_reads = 0, stab_err = 0;
  logic a_pv = 0, a_pr = 0, b_pv = 0, b_pr = 0;
  logic [7:0] a_pd = 0, b_pd = 0;

  always @(posedge clk or posedge areset) begin
    if (areset) begin
      a_pv = 1'b0; b_pv = 1'b0;
      got_a.delete(); got_b.delete();
    end else begin
      if (a_fifo_read && a_fifo_empty) empty_reads++;
      if (b_fifo_read && b_fifo_empty) empty_reads++;
      if (a_pv && !a_pr && (!a_m_valid || a_m_data !== a_pd)) stab_err++;
      if (b_pv && !b_pr && (!b_m_valid || b_m_data !== b_pd)) stab_err++;
      if (a_m_valid && a_m_ready) got_a.push_back(a_m_data);
      if (b_m_valid && b_m_ready) got_b.push_back(b_m_data);
      a_pv = a_m_valid; a_pr = a_m_ready; a_pd = a_m_data;
      b_pv = b_m_valid; b_pr = b_m_ready; b_pd = b_m_data;
    end
  end

  int tests = 0, fails = 0;

  task automatic reset_on;
    @(negedge clk);
    areset = 1'b1;
    a_wr = 0; b_wr = 0;
    a_m_ready = 1'b0; b_m_ready = 1'b0;
    @(negedge clk);
  endtask

  task automatic reset_off;
    @(negedge clk);
    areset = 1'b0;
  endtask

  task automatic put_a(input logic [7:0] w);
    a_mem[a_wr[11:0]] = w;
    a_wr++;
  endtask

  task automatic put_b(input logic [7:0] w);
    b_mem[b_wr[11:0]] = w;
    b_wr++;
  endtask

  task automatic test_reset;
    reset_on;
    put_a(8'h5A); put_b(8'hA5);
    a_m_ready = 1'b1; b_m_ready = 1'b1;
    #1;
    tests++;
    if ({a_fifo_read, a_m_valid, a_m_data, words_a, a_underrun, a_busy} !== 16'h0) begin
      fails++;
      $display("[TB] FAIL reset_a got rd=%b v=%b d=%h w=%h u=%b b=%b want all 0",
               a_fifo_read, a_m_valid, a_m_data, words_a, a_underrun, a_busy);
    end
    tests++;
    if ({b_fifo_read, b_m_valid, b_m_data, words_b, b_underrun, b_busy} !== 28'h0) begin
      fails++;
      $display("[TB] FAIL reset_b got rd=%b v=%b d=%h w=%h u=%b b=%b want all 0",
               b_fifo_read, b_m_valid, b_m_data, words_b, b_underrun, b_busy);
    end
    reset_off;
    #1;
    tests++;
    if (a_fifo_read !== 1'b0 || b_fifo_read !== 1'b0) begin
      fails++;
      $display("[TB] FAIL read_before_edge got a=%b b=%b want 0 0", a_fifo_read, b_fifo_read);
    end
  endtask

  task automatic test_burst;
    logic [7:0] w [4];
    logic exp_rd, exp_v;
    w[0] = 8'h11; w[1] = 8'h22; w[2] = 8'h33; w[3] = 8'h44;
    reset_on;
    for (int i = 0; i < 4; i++) put_a(w[i]);
    a_m_ready = 1'b1;
    reset_off;
    for (int k = 0; k <= 9; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      exp_rd = (k >= 1 && k <= 4);
      exp_v  = (k >= 3 && k <= 6);
      tests++;
      if (a_fifo_read !== exp_rd) begin
        fails++;
        $display("[TB] FAIL burst_read k=%0d got %b want %b", k, a_fifo_read, exp_rd);
      end
      tests++;
      if (a_m_valid !== exp_v) begin
        fails++;
        $display("[TB] FAIL burst_valid k=%0d got %b want %b", k, a_m_valid, exp_v);
      end
      if (exp_v) begin
        tests++;
        if (a_m_data !== w[k-3]) begin
          fails++;
          $display("[TB] FAIL burst_data k=%0d got %h want %h", k, a_m_data, w[k-3]);
        end
      end
    end
    tests++;
    if (words_a !== 4'd4 || a_busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL burst_end got words=%0d busy=%b want 4 0", words_a, a_busy);
    end
  endtask

  task automatic test_backpressure;
    logic [7:0] w [4];
    reset_on;
    for (int i = 0; i < 4; i++) begin
      w[i] = 8'($urandom);
      put_a(w[i]);
    end
    reset_off;
    repeat (8) @(negedge clk);
    #1;
    tests++;
    if (a_rd !== 2 || a_fifo_read !== 1'b0) begin
      fails++;
      $display("[TB] FAIL bp_reads got issued=%0d rd=%b want 2 0", a_rd, a_fifo_read);
    end
    tests++;
    if (a_m_valid !== 1'b1 || a_m_data !== w[0]) begin
      fails++;
      $display("[TB] FAIL bp_hold got v=%b d=%h want 1 %h", a_m_valid, a_m_data, w[0]);
    end
    a_m_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      if (k > 0) begin
        @(negedge clk);
        #1;
      end
      tests++;
      if (a_m_valid !== 1'b1 || a_m_data !== w[k]) begin
        fails++;
        $display("[TB] FAIL bp_release k=%0d got v=%b d=%h want 1 %h", k, a_m_valid, a_m_data, w[k]);
      end
    end
    repeat (3) @(negedge clk);
    tests++;
    if (got_a.size() != 4 || stab_err != 0) begin
      fails++;
      $display("[TB] FAIL bp_stream got words=%0d stab_err=%0d want 4 0", got_a.size(), stab_err);
    end
  endtask

  task automatic test_random;
    logic [7:0] expq[$];
    logic [7:0] w;
    int sent = 0, cyc = 0, shown = 0;
    reset_on;
    reset_off;
    while (got_b.size() < 1000 && cyc < 20000) begin
      @(negedge clk);
      #1;
      cyc++;
      if (sent < 1000 && $urandom_range(3) != 0) begin
        w = 8'($urandom);
        put_b(w);
        expq.push_back(w);
        sent++;
      end
      b_m_ready = 1'($urandom_range(1));
    end
    tests++;
    if (got_b.size() != 1000) begin
      fails++;
      $display("[TB] FAIL random_count got %0d want 1000", got_b.size());
    end
    for (int i = 0; i < got_b.size() && i < expq.size(); i++) begin
      tests++;
      if (got_b[i] !== expq[i]) begin
        fails++;
        if (shown < 10) $display("[TB] FAIL random_data i=%0d got %h want %h", i, got_b[i], expq[i]);
        shown++;
      end
    end
    tests++;
    if (empty_reads != 0 || b_underrun !== 1'b0 || stab_err != 0) begin
      fails++;
      $display("[TB] FAIL random_protocol got empty_reads=%0d underrun=%b stab_err=%0d want 0 0 0",
               empty_reads, b_underrun, stab_err);
    end
  endtask

  task automatic test_empty_midburst;
    logic [7:0] w [4];
    logic exp_rd;
    reset_on;
    for (int i = 0; i < 3; i++) begin
      w[i] = 8'($urandom);
      put_a(w[i]);
    end
    w[3] = 8'($urandom);
    a_m_ready = 1'b1;
    reset_off;
    for (int k = 0; k <= 12; k++) begin
      if (k > 0) @(negedge clk);
      #1;
      exp_rd = (k >= 1 && k <= 3);
      tests++;
      if (a_fifo_read !== exp_rd) begin
        fails++;
        $display("[TB] FAIL gap_read k=%0d got %b want %b", k, a_fifo_read, exp_rd);
      end
      if (k >= 3 && k <= 5) begin
        tests++;
        if (a_m_valid !== 1'b1 || a_m_data !== w[k-3]) begin
          fails++;
          $display("[TB] FAIL gap_data k=%0d got v=%b d=%h want 1 %h", k, a_m_valid, a_m_data, w[k-3]);
        end
      end else if (k >= 6 && k <= 10) begin
        tests++;
        if (a_m_valid !== 1'b0) begin
          fails++;
          $display("[TB] FAIL gap_idle k=%0d got v=%b want 0", k, a_m_valid);
        end
      end else if (k == 11) begin
        tests++;
        if (a_m_valid !== 1'b1 || a_m_data !== w[3]) begin
          fails++;
          $display("[TB] FAIL gap_resume got v=%b d=%h want 1 %h", a_m_valid, a_m_data, w[3]);
        end
      end
      if (k == 9) begin
        put_a(w[3]);
        #1;
        tests++;
        if (a_fifo_read !== 1'b1) begin
          fails++;
          $display("[TB] FAIL gap_refill_read got %b want 1", a_fifo_read);
        end
      end
    end
    tests++;
    if (words_a !== 4'd4) begin
      fails++;
      $display("[TB] FAIL gap_words got %0d want 4", words_a);
    end
  endtask

  task automatic test_reset_midflight;
    logic [7:0] n [3];
    int cyc = 0;
    reset_on;
    for (int i = 0; i < 6; i++) put_b(8'(i + 1));
    b_m_ready = 1'b1;
    reset_off;
    repeat (5) @(negedge clk);
    #1;
    tests++;
    if (b_busy !== 1'b1 || words_b !== 16'd1) begin
      fails++;
      $display("[TB] FAIL flight_pre got busy=%b words=%0d want 1 1", b_busy, words_b);
    end
    #1;
    areset = 1'b1;
    #1;
    tests++;
    if ({b_m_valid, b_fifo_read, b_busy, words_b} !== 19'h0) begin
      fails++;
      $display("[TB] FAIL flight_async got v=%b rd=%b busy=%b words=%0d want 0 0 0 0",
               b_m_valid, b_fifo_read, b_busy, words_b);
    end
    b_wr = 0;
    for (int i = 0; i < 3; i++) begin
      n[i] = 8'hA0 + 8'(i);
      put_b(n[i]);
    end
    #1;
    areset = 1'b0;
    #0.5;
    tests++;
    if (b_fifo_read !== 1'b0) begin
      fails++;
      $display("[TB] FAIL flight_release_read got %b want 0", b_fifo_read);
    end
    while (got_b.size() < 3 && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    repeat (4) @(negedge clk);
    tests++;
    if (got_b.size() != 3) begin
      fails++;
      $display("[TB] FAIL flight_count got %0d want 3", got_b.size());
    end
    for (int i = 0; i < 3 && i < got_b.size(); i++) begin
      tests++;
      if (got_b[i] !== n[i]) begin
        fails++;
        $display("[TB] FAIL flight_data i=%0d got %h want %h", i, got_b[i], n[i]);
      end
    end
  endtask

  task automatic test_wrap;
    bit seen = 0;
    int cyc = 0;
    reset_on;
    for (int i = 0; i < 17; i++) put_a(8'(8'h30 + i));
    a_m_ready = 1'b1;
    reset_off;
    while (got_a.size() < 17 && cyc < 100) begin
      @(negedge clk);
      #1;
      cyc++;
      if (got_a.size() == 16 && !seen) begin
        seen = 1;
        tests++;
        if (words_a !== 4'd0) begin
          fails++;
          $display("[TB] FAIL wrap_zero got %0d want 0", words_a);
        end
      end
    end
    repeat (3) @(negedge clk);
    tests++;
    if (!seen || words_a !== 4'd1 || got_a.size() != 17) begin
      fails++;
      $display("[TB] FAIL wrap_end got seen16=%0d words=%0d delivered=%0d want 1 1 17",
               seen, words_a, got_a.size());
    end
  endtask

  initial begin
    test_reset;
    test_burst;
    test_backpressure;
    test_random;
    test_empty_midburst;
    test_reset_midflight;
    test_wrap;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side drain engine for the dual-clock FIFO, operating in the FIFO's read clock domain.
- Monitors the FIFO's empty flag and issues read strobes to it.
- Captures read data after the dual-port RAM read latency.
- Presents the data as a valid/ready stream to the downstream filter datapath. It holds a small elastic buffer so that one word per cycle is sustained under continuous ready, with no loss and no duplication when downstream back-pressure occurs.

Parameters:
- DWIDTH, 8, data word width; matches the FIFO DWIDTH.
- RD_LAT, 1, cycles from a read strobe until q is valid; legal values are 1 and 2.
- CWIDTH, 16, width of the delivered-word counter.

Ports:
- rd_clk  input  1  single clock; the FIFO read-side clock.
- areset  input  1  asynchronous, active-high reset.
- fifo_empty  input  1  FIFO empty flag; reflects the current read pointer every cycle.
- fifo_q  input  DWIDTH  FIFO read data; valid RD_LAT cycles after fifo_read.
- fifo_read  output  1  FIFO read strobe; one word popped per high cycle.
- m_data  output  DWIDTH  stream data.
- m_valid  output  1  stream valid.
- m_ready  input  1  stream ready from downstream.
- words_out  output  CWIDTH  count of completed stream transfers.
- underrun  output  1  sticky flag; set if fifo_read is ever asserted while fifo_empty is high.
- busy  output  1  high while any read is in flight or any word is buffered.

Behaviour:
- Clock and reset: one clock, rd_clk. Reset is asynchronous and active-high (areset). All state is cleared on areset assertion, independent of the clock.
- Reset values: fifo_read=0, m_valid=0, m_data=0, words_out=0, underrun=0, busy=0. The in-flight counter and buffer are emptied.
- Elastic buffer: BDEPTH = RD_LAT+1 entries, circular, with head/tail pointers and an occupancy count.
- Output registers: m_data and m_valid are driven from the buffer head, which is registered. No combinational path from m_ready to m_valid or m_data.
- Credit rule:
  - credit_used = occupancy + inflight - pop, where pop = m_valid & m_ready.
  - fifo_read = !fifo_empty & (credit_used < BDEPTH).
  - fifo_read is combinational from registered state, m_ready and fifo_empty.
- In-flight tracking:
  - Shift register of depth RD_LAT marks which issued reads are pending.
  - A read issued in cycle t lands: fifo_q is sampled into the buffer tail at the end of cycle t+RD_LAT.
  - inflight is the number of set bits in the shift register.
- Push and pop in the same cycle: both are allowed; occupancy is unchanged; head and tail advance independently.
- Stream rule: once m_valid is high, m_data is held stable until m_valid & m_ready. m_valid drops only after a pop empties the buffer.
- Latency: with an idle pipeline and fifo_empty falling in cycle t, fifo_read is high in t and m_valid is high in t+RD_LAT+1.
- Throughput: with m_ready held high and the FIFO non-empty, fifo_read and m_valid are high every cycle in steady state.
- Back-pressure:
  - When m_ready is low, reads continue until credit_used reaches BDEPTH, then fifo_read stays low.
  - Reads already in flight always find a free buffer slot; overflow is impossible by construction.
- words_out: increments on each pop; wraps from 2^CWIDTH-1 to 0 without saturating.
- underrun: sticky until reset. It cannot be set by a correct implementation and is a verification aid.
- busy = (occupancy != 0) | (inflight != 0).
- FIFO going empty mid-burst: fifo_read deasserts the same cycle. Data already in flight is still delivered.
- Reset mid-operation:
  - In-flight data is discarded.
  - The FIFO read pointer is reset by the same reset domain, so no stale word is delivered after release.
  - The first fifo_read after release is no earlier than the first clock edge with areset low.
- Pointer arithmetic: pointers wrap modulo BDEPTH. For RD_LAT=2, BDEPTH=3 is non-power-of-two, so an explicit compare-and-clear is required at index 2.

Test Plan:
- Reset, then 4 words 0x11,0x22,0x33,0x44 preloaded with fifo_empty=0 and m_ready=1, RD_LAT=1 -> fifo_read high for 4 consecutive cycles. m_data is 0x11..0x44 on consecutive cycles starting 2 cycles after the first read. words_out=4, busy=0 afterwards.
- m_ready=0 with a non-empty FIFO, RD_LAT=1 -> exactly 2 reads issued, then fifo_read=0. m_valid=1 with m_data=first word held stable. Releasing m_ready delivers both words in order with no gap.
- Random m_ready (50%) over 1000 words, RD_LAT=2 -> output sequence equals input sequence exactly. fifo_read never high while fifo_empty=1, and underrun stays 0.
- FIFO empties after 3 words, refills 5 cycles later -> fifo_read drops in the cycle fifo_empty rises. The 3 words complete, m_valid falls, and the stream resumes with word 4 RD_LAT+1 cycles after refill.
- areset pulsed asynchronously between edges while 2 reads are in flight -> m_valid, fifo_read, busy and words_out are 0 immediately. No stale word appears after release.
- CWIDTH=4, stream 17 words -> words_out wraps 15->0 and reads 1 at the end.
